// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_operand_cond.sv
// Converts one operand to an unsigned magnitude plus sign bit.
module mult_operand_cond #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] operand_i,
  input  logic             signed_mode_i,
  output logic [WIDTH-1:0] magnitude_o,
  output logic             sign_o
);

  // The most-negative value negates to itself, which is the correct magnitude
  // when read as unsigned.
  assign sign_o      = signed_mode_i & operand_i[WIDTH-1];
  assign magnitude_o = sign_o ? (~operand_i + WIDTH'(1)) : operand_i;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, fixed WIDTH+1 cycle latency, signed/unsigned per op.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   data_a,
  input  logic [WIDTH-1:0]   data_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output state_e             dbg_state
);

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam int             PW       = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  // Handshake: a request is taken when start=1 at a rising edge while the
  // unit is in IDLE or DONE; busy is high from that edge until the edge that
  // raises done, and done is high for exactly the one cycle after it.

  state_e           state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    result_q, result_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic             sign_a, sign_b;
  logic [WIDTH:0]   upper_sum;
  logic [PW-1:0]    acc_step;

  mult_operand_cond #(.WIDTH(WIDTH)) u_cond_a (
    .operand_i     (data_a),
    .signed_mode_i (signed_mode),
    .magnitude_o   (mag_a),
    .sign_o        (sign_a)
  );

  mult_operand_cond #(.WIDTH(WIDTH)) u_cond_b (
    .operand_i     (data_b),
    .signed_mode_i (signed_mode),
    .magnitude_o   (mag_b),
    .sign_o        (sign_b)
  );

  // The carry out of the upper-half add becomes the new MSB after the shift.
  assign upper_sum = {1'b0, acc_q[PW-1:WIDTH]}
                   + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
  assign acc_step  = {upper_sum, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = CALC;
          mcand_d  = mag_a;
          mplier_d = mag_b;
          neg_d    = sign_a ^ sign_b;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      CALC: begin
        acc_d    = acc_step;
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_d == CNT_LAST) state_d = FINISH;
      end
      FINISH: begin
        // Negating a zero accumulator yields zero, so no -0 case exists.
        result_d = neg_q ? (~acc_q + PW'(1)) : acc_q;
        done_d   = 1'b1;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == CALC) || (state_q == FINISH);
  assign done      = done_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule
